// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared encodings for the IFU/LSU AXI4 arbiter
//   state_e      : arbiter FSM states
//   RESP_*       : AXI response codes (RESP_DECERR doubles as the watchdog code)
//   BURST_INCR   : burst type driven on ar/aw
//   ID_IFU/LSU   : AXI ids identifying the owner of a read
package axi_arb_pkg;
   typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW, WR_B} state_e;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [3:0] ID_IFU      = 4'd0;
   localparam logic [3:0] ID_LSU      = 4'd1;
   localparam logic [2:0] SIZE_WORD   = 3'd2;
endpackage

// File: rtl/axi_arb_rr.sv
// axi_arb_rr: two-way round-robin picker
//   req_ifu_i / req_lsu_i : pending requests
//   last_i                : last grant (0 = IFU, 1 = LSU)
//   gnt_o                 : one-hot grant, bit 0 = IFU, bit 1 = LSU
module axi_arb_rr
   import axi_arb_pkg::*;
(
   input  logic       req_ifu_i,
   input  logic       req_lsu_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);
   // on a tie the requester not granted last wins
   assign gnt_o[0] = req_ifu_i & (~req_lsu_i | last_i);
   assign gnt_o[1] = req_lsu_i & (~req_ifu_i | ~last_i);
endmodule

// File: rtl/axi_arbiter.sv
// axi_arbiter: shares one AXI4 master port between IFU fetches and LSU accesses
//   clock, reset (async, active low)
//   ifu_*        : fetch request/grant/done/data/resp
//   lsu_*        : load/store request/grant/done/data/resp
//   timeout_flag : sticky watchdog error (only with AXI_ARB_TIMEOUT_EN)
//   io_master_*  : AXI4 master bundle, single beat, one transaction outstanding
// Optional feature: define AXI_ARB_TIMEOUT_EN to enable the response watchdog.
module axi_arbiter
   import axi_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ifu_req,
   input  logic [31:0] ifu_addr,
   output logic        ifu_gnt,
   output logic        ifu_done,
   output logic [31:0] ifu_rdata,
   output logic [1:0]  ifu_resp,
   input  logic        lsu_req,
   input  logic        lsu_we,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wstrb,
   input  logic [2:0]  lsu_size,
   output logic        lsu_gnt,
   output logic        lsu_done,
   output logic [31:0] lsu_rdata,
   output logic [1:0]  lsu_resp,
`ifdef AXI_ARB_TIMEOUT_EN
   output logic        timeout_flag,
`endif
   input  logic        io_master_awready,
   output logic        io_master_awvalid,
   output logic [31:0] io_master_awaddr,
   output logic [3:0]  io_master_awid,
   output logic [7:0]  io_master_awlen,
   output logic [2:0]  io_master_awsize,
   output logic [1:0]  io_master_awburst,
   input  logic        io_master_wready,
   output logic        io_master_wvalid,
   output logic [31:0] io_master_wdata,
   output logic [3:0]  io_master_wstrb,
   output logic        io_master_wlast,
   output logic        io_master_bready,
   input  logic        io_master_bvalid,
   input  logic [1:0]  io_master_bresp,
   input  logic [3:0]  io_master_bid,
   input  logic        io_master_arready,
   output logic        io_master_arvalid,
   output logic [31:0] io_master_araddr,
   output logic [3:0]  io_master_arid,
   output logic [7:0]  io_master_arlen,
   output logic [2:0]  io_master_arsize,
   output logic [1:0]  io_master_arburst,
   output logic        io_master_rready,
   input  logic        io_master_rvalid,
   input  logic [1:0]  io_master_rresp,
   input  logic [31:0] io_master_rdata,
   input  logic        io_master_rlast,
   input  logic [3:0]  io_master_rid
);
   state_e      state_q, state_d;
   logic        last_q, last_d;
   logic        owner_q, owner_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [2:0]  size_q, size_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        ifu_done_q, ifu_done_d;
   logic        lsu_done_q, lsu_done_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  resp_q, resp_d;
   logic [1:0]  pick;
   logic        can_gnt;
   logic        aw_ok, w_ok;
   logic        unused_in;

   // single beats only; ids and rlast carry no extra information here
   assign unused_in = ^{io_master_bid, io_master_rid, io_master_rlast};

   axi_arb_rr u_rr (
      .req_ifu_i (ifu_req),
      .req_lsu_i (lsu_req),
      .last_i    (last_q),
      .gnt_o     (pick)
   );

   // no grant while a done pulse is out, so a new grant trails done by a cycle
   assign can_gnt = reset & (state_q == IDLE) & ~ifu_done_q & ~lsu_done_q;
   assign ifu_gnt = can_gnt & pick[0];
   assign lsu_gnt = can_gnt & pick[1];

   assign io_master_arvalid = state_q == RD_AR;
   assign io_master_araddr  = addr_q;
   assign io_master_arid    = owner_q ? ID_LSU : ID_IFU;
   assign io_master_arlen   = 8'd0;
   assign io_master_arsize  = size_q;
   assign io_master_arburst = BURST_INCR;
   assign io_master_awvalid = (state_q == WR_AW) & ~aw_done_q;
   assign io_master_awaddr  = addr_q;
   assign io_master_awid    = ID_LSU;
   assign io_master_awlen   = 8'd0;
   assign io_master_awsize  = size_q;
   assign io_master_awburst = BURST_INCR;
   assign io_master_wvalid  = (state_q == WR_AW) & ~w_done_q;
   assign io_master_wdata   = wdata_q;
   assign io_master_wstrb   = wstrb_q;
   assign io_master_wlast   = io_master_wvalid;
   // ready in IDLE drains beats left over from an abandoned transaction
   assign io_master_rready  = (state_q == IDLE) | (state_q == RD_R);
   assign io_master_bready  = (state_q == IDLE) | (state_q == WR_B);

   assign ifu_done  = ifu_done_q;
   assign lsu_done  = lsu_done_q;
   assign ifu_rdata = rdata_q;
   assign lsu_rdata = rdata_q;
   assign ifu_resp  = resp_q;
   assign lsu_resp  = resp_q;

   assign aw_ok = aw_done_q | io_master_awready;
   assign w_ok  = w_done_q | io_master_wready;

`ifdef AXI_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;
   assign timeout_flag = tmo_q;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      size_d     = size_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      ifu_done_d = 1'b0;
      lsu_done_d = 1'b0;
      rdata_d    = rdata_q;
      resp_d     = resp_q;
      case (state_q)
         IDLE: if (ifu_gnt | lsu_gnt) begin
            last_d  = lsu_gnt;
            owner_d = lsu_gnt;
            addr_d  = lsu_gnt ? lsu_addr : ifu_addr;
            wdata_d = lsu_wdata;
            wstrb_d = lsu_wstrb;
            size_d  = lsu_gnt ? lsu_size : SIZE_WORD;
            state_d = (lsu_gnt & lsu_we) ? WR_AW : RD_AR;
         end
         RD_AR: if (io_master_arready) state_d = RD_R;
         RD_R: if (io_master_rvalid) begin
            state_d    = IDLE;
            ifu_done_d = ~owner_q;
            lsu_done_d = owner_q;
            rdata_d    = io_master_rdata;
            resp_d     = io_master_rresp;
         end
         WR_AW: begin
            // aw and w complete independently; leave once both have
            state_d   = (aw_ok & w_ok) ? WR_B : WR_AW;
            aw_done_d = aw_ok & ~w_ok;
            w_done_d  = w_ok & ~aw_ok;
         end
         WR_B: if (io_master_bvalid) begin
            state_d    = IDLE;
            lsu_done_d = 1'b1;
            resp_d     = io_master_bresp;
         end
         default: state_d = IDLE;
      endcase
`ifdef AXI_ARB_TIMEOUT_EN
      // loaded with 1 at the grant edge, so cnt_q equals cycles since grant
      cnt_d = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
      tmo_d = tmo_q;
      if (state_q != IDLE && state_d != IDLE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
         state_d    = IDLE;
         ifu_done_d = ~owner_q;
         lsu_done_d = owner_q;
         resp_d     = RESP_DECERR;
         aw_done_d  = 1'b0;
         w_done_d   = 1'b0;
         tmo_d      = 1'b1;
      end
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         last_q     <= 1'b0;
         owner_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         size_q     <= '0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         ifu_done_q <= 1'b0;
         lsu_done_q <= 1'b0;
         rdata_q    <= '0;
         resp_q     <= RESP_OKAY;
`ifdef AXI_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         tmo_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         size_q     <= size_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         ifu_done_q <= ifu_done_d;
         lsu_done_q <= lsu_done_d;
         rdata_q    <= rdata_d;
         resp_q     <= resp_d;
`ifdef AXI_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
`endif
      end
   end
endmodule

// File: tb/tb_axi_arbiter.sv
// tb_axi_arbiter: directed self-checking bench for axi_arbiter
module tb_axi_arbiter;
   logic        clock, reset;
   logic        ifu_req, ifu_gnt, ifu_done;
   logic [31:0] ifu_addr, ifu_rdata;
   logic [1:0]  ifu_resp;
   logic        lsu_req, lsu_we, lsu_gnt, lsu_done;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wstrb;
   logic [2:0]  lsu_size;
   logic [1:0]  lsu_resp;
`ifdef AXI_ARB_TIMEOUT_EN
   logic        timeout_flag;
`endif
   logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
   logic        arready, arvalid, rready, rvalid, rlast;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  awid, wstrb, bid, arid, rid;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, bresp, arburst, rresp;
   int          n_chk, n_fail, aw_hs, w_hs;

   axi_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clock(clock), .reset(reset),
      .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt), .ifu_done(ifu_done),
      .ifu_rdata(ifu_rdata), .ifu_resp(ifu_resp),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_wstrb(lsu_wstrb), .lsu_size(lsu_size), .lsu_gnt(lsu_gnt), .lsu_done(lsu_done),
      .lsu_rdata(lsu_rdata), .lsu_resp(lsu_resp),
`ifdef AXI_ARB_TIMEOUT_EN
      .timeout_flag(timeout_flag),
`endif
      .io_master_awready(awready), .io_master_awvalid(awvalid), .io_master_awaddr(awaddr),
      .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
      .io_master_awburst(awburst), .io_master_wready(wready), .io_master_wvalid(wvalid),
      .io_master_wdata(wdata), .io_master_wstrb(wstrb), .io_master_wlast(wlast),
      .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
      .io_master_bid(bid), .io_master_arready(arready), .io_master_arvalid(arvalid),
      .io_master_araddr(araddr), .io_master_arid(arid), .io_master_arlen(arlen),
      .io_master_arsize(arsize), .io_master_arburst(arburst), .io_master_rready(rready),
      .io_master_rvalid(rvalid), .io_master_rresp(rresp), .io_master_rdata(rdata),
      .io_master_rlast(rlast), .io_master_rid(rid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (awvalid && awready) aw_hs++;
      if (wvalid && wready) w_hs++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench still running, required $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // cycle 0: present request(s), check the grant, then scramble fields
   task automatic issue(input logic ir, input logic lr, input logic we, input logic [31:0] a,
                        input logic [2:0] sz, input logic exp_lsu);
      ifu_req = ir; lsu_req = lr; lsu_we = we;
      ifu_addr = a; lsu_addr = a; lsu_size = sz;
      #1;
      chk("ifu_gnt", ifu_gnt, !exp_lsu);
      chk("lsu_gnt", lsu_gnt, exp_lsu);
      tick();
      ifu_req = 0; lsu_req = 0;
      ifu_addr = 32'hFFFF_FFFF; lsu_addr = 32'hFFFF_FFFF;
      lsu_size = 3'd7; lsu_wdata = 32'h0; lsu_wstrb = 4'h0;
   endtask

   // cycles 1..4 of a read with a zero-wait slave
   task automatic read_rest(input logic exp_lsu, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] d, input logic [1:0] rr);
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, a);
      chk("arid", arid, {3'b0, exp_lsu});
      chk("arsize", arsize, sz);
      chk("arlen", arlen, 0);
      chk("arburst", arburst, 2'b01);
      chk("rready_ar", rready, 0);
      arready = 1;
      tick();
      arready = 0;
      chk("arvalid_r", arvalid, 0);
      chk("rready_r", rready, 1);
      rvalid = 1; rdata = d; rresp = rr;
      tick();
      rvalid = 0; rdata = 32'h0; rresp = 2'b00;
      chk("done_own", exp_lsu ? lsu_done : ifu_done, 1);
      chk("done_oth", exp_lsu ? ifu_done : lsu_done, 0);
      chk("rdata", exp_lsu ? lsu_rdata : ifu_rdata, d);
      chk("resp", exp_lsu ? lsu_resp : ifu_resp, rr);
      tick();
      chk("done_end", ifu_done | lsu_done, 0);
      chk("no_retry", arvalid, 0);
   endtask

   initial begin
      bit e;
      n_chk = 0; n_fail = 0; aw_hs = 0; w_hs = 0;
      reset = 0; ifu_req = 1; ifu_addr = 0; lsu_req = 0; lsu_we = 0; lsu_addr = 0;
      lsu_wdata = 0; lsu_wstrb = 0; lsu_size = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
      arready = 0; rvalid = 0; rresp = 0; rdata = 0; rlast = 1; rid = 0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_ifu_gnt", ifu_gnt, 0);
      chk("rst_valids", {arvalid, awvalid, wvalid}, 0);
      chk("rst_done", {ifu_done, lsu_done}, 0);
      chk("rst_rdata", ifu_rdata, 0);
      chk("rst_resp", ifu_resp, 0);
`ifdef AXI_ARB_TIMEOUT_EN
      chk("rst_tmo", timeout_flag, 0);
`endif
      ifu_req = 0; reset = 1;
      tick();
      issue(1, 0, 0, 32'h8000_0000, 3'd2, 0);
      read_rest(0, 32'h8000_0000, 3'd2, 32'hDEAD_BEEF, 2'b00);
      for (int i = 0; i < 3; i++) begin
         e = (i != 1);
         issue(1, 1, 0, 32'h100 + 32'(i * 4), 3'd2, e);
         read_rest(e, 32'h100 + 32'(i * 4), 3'd2, 32'h1000 + 32'(i), 2'b00);
      end
      aw_hs = 0; w_hs = 0;
      lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'b0011;
      issue(0, 1, 1, 32'h0F00_0010, 3'd2, 1);
      chk("awvalid1", awvalid, 1);
      chk("wvalid1", wvalid, 1);
      chk("wlast1", wlast, 1);
      chk("awaddr", awaddr, 32'h0F00_0010);
      chk("awid", awid, 1);
      chk("awsize", awsize, 2);
      chk("wdata", wdata, 32'h1234_5678);
      chk("wstrb", wstrb, 4'b0011);
      wready = 1;
      tick();
      wready = 0;
      chk("wvalid2", wvalid, 0);
      chk("awvalid2", awvalid, 1);
      tick();
      awready = 1;
      tick();
      awready = 0;
      chk("wr_b_valids", {awvalid, wvalid}, 0);
      chk("bready", bready, 1);
      chk("rready_b", rready, 0);
      bvalid = 1; bresp = 2'b00;
      tick();
      bvalid = 0;
      chk("wr_done", lsu_done, 1);
      chk("wr_resp", lsu_resp, 0);
      chk("aw_hs", aw_hs, 1);
      chk("w_hs", w_hs, 1);
      tick();
      chk("wr_done_end", lsu_done, 0);
      issue(0, 1, 1, 32'h0000_0040, 3'd0, 1);
      awready = 1; wready = 1;
      tick();
      awready = 0; wready = 0;
      chk("same_cyc_b", {awvalid, wvalid, bready}, 3'b001);
      bvalid = 1; bresp = 2'b10;
      tick();
      bvalid = 0; bresp = 0;
      chk("same_cyc_done", lsu_done, 1);
      chk("same_cyc_resp", lsu_resp, 2'b10);
      tick();
      issue(0, 1, 0, 32'h2000_0004, 3'd1, 1);
      read_rest(1, 32'h2000_0004, 3'd1, 32'hCAFE_F00D, 2'b10);
      issue(1, 0, 0, 32'h3000_0000, 3'd2, 0);
      arready = 1;
      tick();
      arready = 0;
      reset = 0;
      #1;
      chk("mid_rst_ar", arvalid, 0);
      chk("mid_rst_rready", rready, 1);
      tick();
      reset = 1;
      tick();
      rvalid = 1; rdata = 32'hBAD0_BAD0;
      tick();
      rvalid = 0;
      chk("late_beat_done", {ifu_done, lsu_done}, 0);
      chk("late_beat_idle", arvalid, 0);
      tick();
      chk("late_beat_done2", {ifu_done, lsu_done}, 0);
      issue(1, 0, 0, 32'h8000_0100, 3'd2, 0);
      read_rest(0, 32'h8000_0100, 3'd2, 32'h0BAD_F00D, 2'b00);
`ifdef AXI_ARB_TIMEOUT_EN
      issue(1, 0, 0, 32'h8000_0200, 3'd2, 0);
      arready = 1;
      tick();
      arready = 0;
      for (int i = 3; i < 8; i++) begin
         tick();
         chk("tmo_wait", ifu_done, 0);
      end
      tick();
      chk("tmo_done", ifu_done, 1);
      chk("tmo_resp", ifu_resp, 2'b11);
      chk("tmo_flag", timeout_flag, 1);
      tick();
      chk("tmo_sticky", timeout_flag, 1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning response-watchdog limit in cycles (used only when AXI_ARB_TIMEOUT_EN is defined).
REQ-002 SHALL have ports `clock` (in, 1, sole clock) and `reset` (in, 1, asynchronous, active-low reset).
REQ-003 SHALL have IFU request ports, listed first to last:
- `ifu_req` (in, 1, fetch request).
- `ifu_addr` (in, 32, fetch address).
- `ifu_gnt` (out, 1, request accepted).
- `ifu_done` (out, 1, data valid).
- `ifu_rdata` (out, 32, fetched word).
- `ifu_resp` (out, 2, AXI response).
REQ-004 SHALL have LSU request ports, listed first to last:
- `lsu_req` (in, 1, request).
- `lsu_we` (in, 1, 1 means write).
- `lsu_addr` (in, 32).
- `lsu_wdata` (in, 32).
- `lsu_wstrb` (in, 4).
- `lsu_size` (in, 3, AXI size).
- `lsu_gnt` (out, 1).
- `lsu_done` (out, 1).
- `lsu_rdata` (out, 32).
- `lsu_resp` (out, 2).
REQ-005 SHALL have `timeout_flag` (out, 1, sticky watchdog error); this port is present only with AXI_ARB_TIMEOUT_EN.
REQ-006 SHALL expose the full io_master_* AXI4 master bundle (aw/w/b/ar/r channels), with the same names and widths as the core top-level bus: 32-bit addr/data, 4-bit id, 8-bit len.

Function
REQ-007 SHALL implement FSM states IDLE, RD_AR, RD_R, WR_AW, WR_B; at most one transaction is outstanding.
REQ-008 In IDLE, the arbiter SHALL choose one requester with a round-robin policy using a last-grant bit. Ties go to the requester not granted last. The last-grant bit resets to IFU, so LSU wins the first tie.
REQ-009 SHALL pulse the winner's gnt for exactly one cycle in IDLE. In that same cycle it SHALL latch addr, we, wdata, wstrb and size, and move to RD_AR (read) or WR_AW (write) on the next edge.
REQ-010 Requesters SHALL hold req and fields stable until gnt; the arbiter SHALL ignore field changes after the grant.
REQ-011 In RD_AR, the arbiter SHALL hold arvalid=1 with latched araddr until arready, then go to RD_R. Fixed fields:
- arlen=0, arburst=2'b01.
- arid=0 for IFU, 1 for LSU.
- arsize=3'd2 for IFU, latched lsu_size for LSU.
REQ-012 In WR_AW, the arbiter SHALL assert awvalid and wvalid together, with wlast=wvalid, awlen=0, awburst=2'b01, awid=1 and awsize=lsu_size. It SHALL track aw and w handshakes independently, deassert each channel after its own handshake, and go to WR_B once both are done (including the same-cycle case).
REQ-013 rready SHALL be 1 in RD_R and IDLE; bready SHALL be 1 in WR_B and IDLE. Beats arriving in IDLE SHALL be discarded.
REQ-014 On the r handshake in RD_R, the arbiter SHALL pulse the owner's done for one cycle, present rdata/rresp in that cycle, and return to IDLE.
REQ-015 On the b handshake in WR_B, it SHALL pulse lsu_done with lsu_resp=bresp, and lsu_rdata is don't-care.
REQ-016 Error responses SHALL complete normally with resp passed through; the arbiter SHALL NOT retry.
REQ-017 A new grant SHALL occur no earlier than the cycle after done. Minimum read latency is gnt to done in 3 cycles with zero-wait slave.

Reset
REQ-018 Asserting `reset` low SHALL asynchronously force state=IDLE, all valids=0, gnt/done=0, rdata/resp=0, last-grant=IFU and timeout_flag=0.
REQ-019 A reset mid-transaction SHALL abandon the transaction with no done pulse; late beats are then drained per REQ-013.

Configuration
REQ-020 With AXI_ARB_TIMEOUT_EN defined, the arbiter SHALL count cycles in any non-IDLE state. At TIMEOUT_CYCLES it SHALL:
- pulse the owner's done with resp=2'b11;
- set timeout_flag (sticky until reset);
- return to IDLE.
REQ-021 Without AXI_ARB_TIMEOUT_EN, the counter and timeout_flag SHALL be absent and the FSM SHALL wait indefinitely.

Structure
REQ-022 Package axi_arb_pkg SHALL hold the state encoding, RESP_OKAY/SLVERR/DECERR, BURST_INCR, ID_IFU=0 and ID_LSU=1.
REQ-023 The two-way round-robin picker SHALL be sub-module axi_arb_rr (inputs: two requests and last-grant; output: one-hot grant).

Verification
REQ-024 IFU read 0x8000_0000, with zero-wait slave returning 0xDEADBEEF -> ifu_gnt at cycle 0, arid=0, arsize=2, ifu_done at cycle 3 with ifu_rdata=0xDEADBEEF and resp=0.
REQ-025 IFU and LSU request in the same cycle, three times in a row -> grants go LSU, IFU, LSU.
REQ-026 LSU write 0x0F00_0010, wdata 0x12345678, wstrb 4'b0011, with awready 2 cycles after wready -> aw/w each handshake once, lsu_done one cycle after bvalid, resp=0.
REQ-027 LSU read with rresp=2'b10 -> lsu_done with lsu_resp=2'b10, no retry, FSM returns to IDLE.
REQ-028 Reset pulled low while in RD_R, then rvalid arrives after release -> no done pulse, beat drained, next request served normally.
REQ-029 With AXI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, a slave that never sends rvalid -> done with resp=2'b11 at cycle 8, timeout_flag=1.
